// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg: AHB/APB encodings, bridge FSM states and the transfer size/alignment check
package ahb_apb_pkg;
    typedef enum logic [1:0] {TR_IDLE = 2'b00, TR_BUSY = 2'b01, TR_NONSEQ = 2'b10, TR_SEQ = 2'b11} htrans_t;
    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    typedef enum logic [2:0] {ST_IDLE, ST_WLATCH, ST_SETUP, ST_ACCESS, ST_ERR1, ST_ERR2} bridge_state_t;
    function automatic logic size_ok(input logic [2:0] hsize, input logic [2:0] addr_lsbs, input int data_width);
        int nbytes;
        nbytes = 1 << hsize;
        return (nbytes <= data_width / 8) && ((int'(addr_lsbs) & (nbytes - 1)) == 0);
    endfunction
endpackage

// File: rtl/apb_strb_gen.sv
// apb_strb_gen: byte strobes and size/alignment legality from HSIZE and the low address bits
module apb_strb_gen import ahb_apb_pkg::*; #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]                       hsize_i,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]  addr_i,
    input  logic                             write_i,
    output logic [DATA_WIDTH/8-1:0]          strb_o,
    output logic                             ok_o
);
    always_comb begin
        ok_o = size_ok(hsize_i, 3'(addr_i), DATA_WIDTH);
        strb_o = '0;
        for (int i = 0; i < DATA_WIDTH / 8; i++)
            strb_o[i] = write_i && ok_o && i >= int'(addr_i) && i < int'(addr_i) + (1 << hsize_i);
    end
endmodule

// File: rtl/ahb_apb_bridge_mc.sv
// ahb_apb_bridge_mc: multi-slave AHB-Lite to APB4 bridge with strobes, error responses and PREADY watchdog
module ahb_apb_bridge_mc import ahb_apb_pkg::*; #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NSLV       = 4,
    parameter int SEL_LSB    = 12,
    parameter int TIMEOUT    = 256
) (
    input  logic                    clock,
    input  logic                    HRESETn,
    input  logic                    HSELAPBif,
    input  logic                    HREADYin,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic                    HWRITE,
    input  logic [1:0]              HTRANS,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [DATA_WIDTH-1:0]   HWDATA,
    output logic [DATA_WIDTH-1:0]   HRDATA,
    output logic [1:0]              HRESP,
    output logic                    HREADYout,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic                    PWRITE,
    output logic                    PENABLE,
    output logic [NSLV-1:0]         PSEL,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);
    localparam int SW   = DATA_WIDTH / 8;
    localparam int LW   = $clog2(SW);
    localparam int IW   = NSLV > 1 ? $clog2(NSLV) : 1;
    localparam int CW   = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam int TMAX = TIMEOUT > 0 ? TIMEOUT - 1 : 0;

    bridge_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [SW-1:0]         strb_q, strb_c;
    logic [IW-1:0]         idx_q, idx_c;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  valid, size_ok_c, mapped, done, expire, cap_win, cap, unused;

    assign unused  = ^HBURST;
    assign idx_c   = HADDR[SEL_LSB +: IW];
    assign mapped  = {1'b0, idx_c} < (IW+1)'(NSLV);
    assign valid   = HSELAPBif && HREADYin && (HTRANS == TR_NONSEQ || HTRANS == TR_SEQ);
    assign done    = state_q == ST_ACCESS && PREADY && !PSLVERR;
    assign expire  = TIMEOUT != 0 && state_q == ST_ACCESS && !PREADY && cnt_q == CW'(TMAX);
    assign cap_win = state_q == ST_IDLE || state_q == ST_ERR2 || done;
    assign cap     = valid && cap_win;

    apb_strb_gen #(.DATA_WIDTH(DATA_WIDTH)) u_strb (
        .hsize_i (HSIZE),
        .addr_i  (HADDR[LW-1:0]),
        .write_i (HWRITE),
        .strb_o  (strb_c),
        .ok_o    (size_ok_c)
    );

    always_comb begin
        state_d = state_q;
        cnt_d = '0;
        case (state_q)
            ST_IDLE, ST_ERR2: state_d = ST_IDLE;
            ST_WLATCH:        state_d = ST_SETUP;
            ST_SETUP:         state_d = ST_ACCESS;
            ST_ACCESS: begin
                state_d = PREADY ? (PSLVERR ? ST_ERR1 : ST_IDLE) : (expire ? ST_ERR1 : ST_ACCESS);
                cnt_d = (PREADY || expire) ? '0 : cnt_q + 1'b1;
            end
            ST_ERR1:          state_d = ST_ERR2;
            default:          state_d = ST_IDLE;
        endcase
        if (cap)
            state_d = !(mapped && size_ok_c) ? ST_ERR1 : HWRITE ? ST_WLATCH : ST_SETUP;
    end

    always_ff @(posedge clock or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            strb_q   <= '0;
            idx_q    <= '0;
            pwdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cap) begin
                addr_q  <= HADDR;
                write_q <= HWRITE;
                strb_q  <= strb_c;
                idx_q   <= idx_c;
            end
            if (state_q == ST_WLATCH)
                pwdata_q <= HWDATA;
        end
    end

    assign HREADYout = cap_win;
    assign HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = (done && !write_q) ? PRDATA : '0;
    assign PENABLE   = state_q == ST_ACCESS;
    assign PSEL      = (state_q == ST_SETUP || state_q == ST_ACCESS) ? (NSLV'(1) << idx_q) : '0;
    assign PADDR     = addr_q;
    assign PWRITE    = write_q;
    assign PSTRB     = strb_q;
    assign PWDATA    = pwdata_q;
endmodule

// File: tb/tb_ahb_apb_bridge_mc.sv
// tb_ahb_apb_bridge_mc: scoreboard bench for the multi-slave AHB-to-APB bridge (3 slaves, 8-cycle watchdog)
module tb_ahb_apb_bridge_mc;
    import ahb_apb_pkg::*;

    logic        clock = 0, HRESETn = 0, HSELAPBif = 0, HREADYin = 1, HWRITE = 0;
    logic [31:0] HADDR = 0, HWDATA = 0, HRDATA, PADDR, PWDATA, PRDATA;
    logic [1:0]  HTRANS = 0, HRESP;
    logic [2:0]  HSIZE = 0, HBURST = 0;
    logic        HREADYout, PWRITE, PENABLE, PREADY, PSLVERR;
    logic [3:0]  PSTRB;
    logic [2:0]  PSEL;
    int          waits = 0, acc_cnt = 0, sel_seen = 0, apb_done = 0;
    int          vectors = 0, miscompares = 0;
    logic        slverr = 0;
    logic [31:0] rdata = 0;
    logic [2:0]  s_psel = 0;
    logic [3:0]  s_pstrb = 0;
    logic [31:0] s_paddr = 0, s_pwdata = 0;
    logic        s_pwrite = 0;
    typedef struct {logic [31:0] data; logic [1:0] resp;} exp_t;
    exp_t sb[$];

    ahb_apb_bridge_mc #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NSLV(3), .SEL_LSB(12), .TIMEOUT(8)) dut (
        .clock(clock), .HRESETn(HRESETn), .HSELAPBif(HSELAPBif), .HREADYin(HREADYin),
        .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HRESP(HRESP), .HREADYout(HREADYout),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PWRITE(PWRITE), .PENABLE(PENABLE),
        .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 clock = ~clock;
    assign PRDATA  = rdata;
    assign PREADY  = acc_cnt >= waits;
    assign PSLVERR = slverr;

    always @(posedge clock) begin
        acc_cnt <= (PENABLE && !PREADY) ? acc_cnt + 1 : 0;
        if (PSEL != 0) sel_seen <= sel_seen + 1;
        if (PENABLE && PREADY) apb_done <= apb_done + 1;
        if (PSEL != 0 && !PENABLE) begin
            s_psel   <= PSEL;
            s_paddr  <= PADDR;
            s_pstrb  <= PSTRB;
            s_pwdata <= PWDATA;
            s_pwrite <= PWRITE;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input string tag, input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [31:0] rd, input int wt, input logic se,
                        input logic [1:0] eresp, input int elow, input int esel,
                        input logic [2:0] epsel, input logic [3:0] estrb);
        int low, s0;
        logic [1:0] lowresp;
        exp_t e;
        @(posedge clock); #1;
        waits = wt; slverr = se; rdata = rd;
        HSELAPBif = 1; HTRANS = TR_NONSEQ; HADDR = a; HWRITE = w; HSIZE = sz; HBURST = 3'b000;
        sb.push_back('{data: (!w && eresp == HRESP_OKAY) ? rd : 32'h0, resp: eresp});
        s0 = sel_seen;
        @(posedge clock); #1;
        HTRANS = TR_IDLE; HSELAPBif = 0; HWDATA = wd;
        low = 0; lowresp = 2'b11;
        @(negedge clock);
        while (!HREADYout && low < 60) begin
            low++;
            lowresp = HRESP;
            @(negedge clock);
        end
        check({tag, "_ready"}, HREADYout, 1);
        e = sb.pop_front();
        check({tag, "_hrdata"}, HRDATA, e.data);
        check({tag, "_hresp"}, HRESP, e.resp);
        check({tag, "_lowcyc"}, low, elow);
        check({tag, "_lowresp"}, lowresp, eresp);
        @(posedge clock); #1;
        check({tag, "_selcyc"}, sel_seen - s0, esel);
        if (esel > 0) begin
            check({tag, "_psel"}, s_psel, epsel);
            check({tag, "_paddr"}, s_paddr, a);
            check({tag, "_pstrb"}, s_pstrb, estrb);
            check({tag, "_pwrite"}, s_pwrite, w);
            if (w) check({tag, "_pwdata"}, s_pwdata, wd);
        end
    endtask

    initial begin
        int low, d0;
        logic [31:0] a0;
        exp_t e;
        repeat (2) @(posedge clock);
        #1;
        check("rst_hready", HREADYout, 1);
        check("rst_hresp", HRESP, 0);
        check("rst_hrdata", HRDATA, 0);
        check("rst_apb", {PSEL, PENABLE, PWRITE, PSTRB}, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        HRESETn = 1;

        xfer("rd_s2",   32'h0000_2004, 0, 3'd2, 32'h0,         32'hCAFE_F00D, 0,   0, HRESP_OKAY,  1,  2, 3'b100, 4'b0000);
        xfer("wr_half", 32'h0000_1002, 1, 3'd1, 32'hAAAA_0000, 32'h0,         0,   0, HRESP_OKAY,  2,  2, 3'b010, 4'b1100);
        xfer("wr_byte", 32'h0000_0003, 1, 3'd0, 32'h1200_0000, 32'h0,         0,   0, HRESP_OKAY,  2,  2, 3'b001, 4'b1000);
        xfer("wr_wait", 32'h0000_2008, 1, 3'd2, 32'h5555_AAAA, 32'h0,         2,   0, HRESP_OKAY,  4,  4, 3'b100, 4'b1111);
        xfer("unmap",   32'h0000_7000, 0, 3'd2, 32'h0,         32'hDEAD_BEEF, 0,   0, HRESP_ERROR, 1,  0, 3'b000, 4'b0000);
        xfer("size3",   32'h0000_0000, 0, 3'd3, 32'h0,         32'hDEAD_BEEF, 0,   0, HRESP_ERROR, 1,  0, 3'b000, 4'b0000);
        xfer("unalign", 32'h0000_1002, 1, 3'd2, 32'h0BAD_0BAD, 32'h0,         0,   0, HRESP_ERROR, 1,  0, 3'b000, 4'b0000);
        xfer("slverr",  32'h0000_2000, 0, 3'd2, 32'h0,         32'h1111_2222, 0,   1, HRESP_ERROR, 3,  2, 3'b100, 4'b0000);
        xfer("wdog",    32'h0000_0008, 0, 3'd2, 32'h0,         32'h3333_4444, 100, 0, HRESP_ERROR, 10, 9, 3'b001, 4'b0000);

        a0 = 32'h0000_0010;
        d0 = apb_done;
        waits = 0; slverr = 0;
        @(posedge clock); #1;
        HSELAPBif = 1; HTRANS = TR_NONSEQ; HADDR = a0; HWRITE = 0; HSIZE = 3'd2; HBURST = 3'b011;
        sb.push_back('{data: 32'hB0B0_0000, resp: HRESP_OKAY});
        for (int b = 0; b < 4; b++) begin
            @(posedge clock); #1;
            waits = (b == 2) ? 3 : 0;
            rdata = 32'hB0B0_0000 + b;
            if (b < 3) begin
                HTRANS = TR_SEQ;
                HADDR = a0 + 4 * (b + 1);
                sb.push_back('{data: 32'hB0B0_0000 + b + 1, resp: HRESP_OKAY});
            end else begin
                HTRANS = TR_IDLE;
                HSELAPBif = 0;
            end
            low = 0;
            @(negedge clock);
            check("burst_setup", {PSEL, PENABLE}, {3'b001, 1'b0});
            while (!HREADYout && low < 60) begin
                low++;
                @(negedge clock);
            end
            check("burst_ready", HREADYout, 1);
            e = sb.pop_front();
            check("burst_hrdata", HRDATA, e.data);
            check("burst_hresp", HRESP, e.resp);
            check("burst_lowcyc", low, (b == 2) ? 4 : 1);
        end
        @(posedge clock); #1;
        HBURST = 3'b000;
        check("burst_apbxfers", apb_done - d0, 4);

        @(posedge clock); #1;
        waits = 100;
        HSELAPBif = 1; HTRANS = TR_NONSEQ; HADDR = 32'h0000_200C; HWRITE = 0; HSIZE = 3'd2;
        @(posedge clock); #1;
        HTRANS = TR_IDLE; HSELAPBif = 0;
        low = 0;
        @(negedge clock);
        while (!PENABLE && low < 10) begin
            low++;
            @(negedge clock);
        end
        check("rst_in_access", {PSEL, PENABLE}, {3'b100, 1'b1});
        #2 HRESETn = 0;
        #1;
        check("arst_psel", PSEL, 0);
        check("arst_penable", PENABLE, 0);
        check("arst_hready", HREADYout, 1);
        check("arst_hresp", HRESP, 0);
        check("arst_paddr", PADDR, 0);
        @(posedge clock); #1;
        HRESETn = 1; waits = 0;
        xfer("rd_after", 32'h0000_100C, 0, 3'd2, 32'h0, 32'h1234_5678, 0, 0, HRESP_OKAY, 1, 2, 3'b010, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
